// File: rtl/router_pkg.sv
// Shared types for the per-master request router.
package router_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2,
        ERR       = 2'd3
    } state_t;

    typedef enum logic {
        CMD_READ  = 1'b0,
        CMD_WRITE = 1'b1
    } cmd_t;

endpackage

// File: rtl/master_request_router_slave_addr_decoder.sv
// Select field to one-hot slave decode; handles non-power-of-two slave counts.
module slave_addr_decoder #(
    parameter int QTY_OF_DEVICES = 4,
    parameter int SEL_W          = $clog2(QTY_OF_DEVICES)
) (
    input  logic [SEL_W-1:0]          sel,
    input  logic                      en,
    output logic [QTY_OF_DEVICES-1:0] onehot,
    output logic                      in_range
);

    // Codes at or above QTY_OF_DEVICES match no bit, so in_range falls out.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < QTY_OF_DEVICES; i++) begin
            onehot[i] = en && (sel == SEL_W'(i));
        end
    end

    assign in_range = |onehot;

endmodule

// File: rtl/master_request_router.sv
// Per-master front end: capture, decode, request/grant, read response, timeout.
module master_request_router
    import router_pkg::*;
#(
    parameter int QTY_OF_DEVICES = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             m_req,
    input  logic                             m_cmd,
    input  logic [ADDR_W-1:0]                m_addr,
    input  logic [DATA_W-1:0]                m_wdata,
    output logic                             m_busy,
    output logic                             m_ack,
    output logic                             m_resp,
    output logic [DATA_W-1:0]                m_rdata,
    output logic                             m_err,
    output logic [QTY_OF_DEVICES-1:0]        request_to_arbiters,
    output logic                             s_cmd,
    output logic [ADDR_W-1:0]                s_addr,
    output logic [DATA_W-1:0]                s_wdata,
    input  logic [QTY_OF_DEVICES-1:0]        grant_from_arbiters,
    input  logic [QTY_OF_DEVICES-1:0]        resp_from_slaves,
    input  logic [QTY_OF_DEVICES*DATA_W-1:0] rdata_from_slaves
);

    localparam int SEL_W = $clog2(QTY_OF_DEVICES);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [SEL_W-1:0]          sel_q, sel_d;
    logic [QTY_OF_DEVICES-1:0] req_d;
    logic                      busy_d, ack_d, resp_d, err_d;
    logic [DATA_W-1:0]         rdata_d;
    logic                      cmd_d;
    logic [ADDR_W-1:0]         addr_d;
    logic [DATA_W-1:0]         wdata_d;

    logic                      dec_en;
    logic [QTY_OF_DEVICES-1:0] dec_oh;
    logic                      dec_ok;
    logic                      hit_grant;
    logic                      sel_resp;
    logic [DATA_W-1:0]         sel_rdata;

    assign dec_en = (state_q == IDLE) && m_req;

    slave_addr_decoder #(
        .QTY_OF_DEVICES (QTY_OF_DEVICES),
        .SEL_W          (SEL_W)
    ) u_dec (
        .sel      (m_addr[ADDR_W-1 -: SEL_W]),
        .en       (dec_en),
        .onehot   (dec_oh),
        .in_range (dec_ok)
    );

    // Only the bit we are driving counts; stray grants are ignored.
    assign hit_grant = |(grant_from_arbiters & request_to_arbiters);

    always_comb begin
        sel_resp  = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < QTY_OF_DEVICES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_resp  = resp_from_slaves[i];
                sel_rdata = rdata_from_slaves[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        req_d   = '0;
        ack_d   = 1'b0;
        resp_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
        cmd_d   = s_cmd;
        addr_d  = s_addr;
        wdata_d = s_wdata;
        unique case (state_q)
            IDLE: begin
                if (m_req) begin
                    cmd_d   = m_cmd;
                    addr_d  = m_addr;
                    wdata_d = m_wdata;
                    sel_d   = m_addr[ADDR_W-1 -: SEL_W];
                    cnt_d   = '0;
                    if (dec_ok) begin
                        state_d = REQ;
                        req_d   = dec_oh;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            REQ: begin
                // Grant beats a simultaneous timeout.
                if (hit_grant) begin
                    ack_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = (cmd_t'(s_cmd) == CMD_WRITE) ? IDLE : WAIT_RESP;
                end else if (cnt_q == LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    req_d = request_to_arbiters;
                end
            end
            WAIT_RESP: begin
                if (sel_resp) begin
                    resp_d  = 1'b1;
                    rdata_d = sel_rdata;
                    state_d = IDLE;
                end else if (cnt_q == LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ERR: begin
                resp_d  = 1'b1;
                err_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= IDLE;
            cnt_q               <= '0;
            sel_q               <= '0;
            request_to_arbiters <= '0;
            m_busy              <= 1'b0;
            m_ack               <= 1'b0;
            m_resp              <= 1'b0;
            m_err               <= 1'b0;
            m_rdata             <= '0;
            s_cmd               <= 1'b0;
            s_addr              <= '0;
            s_wdata             <= '0;
        end else begin
            state_q             <= state_d;
            cnt_q               <= cnt_d;
            sel_q               <= sel_d;
            request_to_arbiters <= req_d;
            m_busy              <= busy_d;
            m_ack               <= ack_d;
            m_resp              <= resp_d;
            m_err               <= err_d;
            m_rdata             <= rdata_d;
            s_cmd               <= cmd_d;
            s_addr              <= addr_d;
            s_wdata             <= wdata_d;
        end
    end

endmodule

// File: tb/tb_master_request_router.sv
// Directed bench: four-slave router with short timeout, plus a three-slave one.
module tb_master_request_router;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // four-slave instance, TIMEOUT_CYCLES = 8
    logic         m_req = 0, m_cmd = 0;
    logic [31:0]  m_addr = '0, m_wdata = '0;
    logic         m_busy, m_ack, m_resp, m_err;
    logic [31:0]  m_rdata;
    logic [3:0]   req;
    logic         s_cmd;
    logic [31:0]  s_addr, s_wdata;
    logic [3:0]   grant = '0, sresp = '0;
    logic [127:0] rdata = '0;

    master_request_router #(
        .QTY_OF_DEVICES (4),
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .m_req               (m_req),
        .m_cmd               (m_cmd),
        .m_addr              (m_addr),
        .m_wdata             (m_wdata),
        .m_busy              (m_busy),
        .m_ack               (m_ack),
        .m_resp              (m_resp),
        .m_rdata             (m_rdata),
        .m_err               (m_err),
        .request_to_arbiters (req),
        .s_cmd               (s_cmd),
        .s_addr              (s_addr),
        .s_wdata             (s_wdata),
        .grant_from_arbiters (grant),
        .resp_from_slaves    (sresp),
        .rdata_from_slaves   (rdata)
    );

    // three-slave instance
    logic        m_req3 = 0, m_cmd3 = 0;
    logic [31:0] m_addr3 = '0, m_wdata3 = '0;
    logic        m_busy3, m_ack3, m_resp3, m_err3;
    logic [31:0] m_rdata3;
    logic [2:0]  req3;
    logic        s_cmd3;
    logic [31:0] s_addr3, s_wdata3;
    logic [2:0]  grant3 = '0, sresp3 = '0;
    logic [95:0] rdata3 = '0;

    master_request_router #(
        .QTY_OF_DEVICES (3),
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut3 (
        .clk                 (clk),
        .rst_n               (rst_n),
        .m_req               (m_req3),
        .m_cmd               (m_cmd3),
        .m_addr              (m_addr3),
        .m_wdata             (m_wdata3),
        .m_busy              (m_busy3),
        .m_ack               (m_ack3),
        .m_resp              (m_resp3),
        .m_rdata             (m_rdata3),
        .m_err               (m_err3),
        .request_to_arbiters (req3),
        .s_cmd               (s_cmd3),
        .s_addr              (s_addr3),
        .s_wdata             (s_wdata3),
        .grant_from_arbiters (grant3),
        .resp_from_slaves    (sresp3),
        .rdata_from_slaves   (rdata3)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_busy", m_busy, 0);
        chk("rst_ack", m_ack, 0);
        chk("rst_resp", m_resp, 0);
        chk("rst_err", m_err, 0);
        chk("rst_rdata", m_rdata, 0);
        chk("rst_req", req, 0);
        chk("rst_s", {s_cmd, s_addr, s_wdata}, 0);
        rst_n = 1'b1;
        step();

        // write to slave 2, grant on the third request cycle
        m_req = 1; m_cmd = 1; m_addr = 32'h8000_0010; m_wdata = 32'h1234_5678;
        step();
        m_req = 0;
        chk("wr_req0", req, 4'b0100);
        chk("wr_busy0", m_busy, 1);
        chk("wr_saddr", s_addr, 32'h8000_0010);
        chk("wr_swdata", s_wdata, 32'h1234_5678);
        chk("wr_scmd", s_cmd, 1);
        grant = 4'b1011;
        step();
        grant = 0;
        chk("wr_req1", req, 4'b0100);
        chk("wr_ack1", m_ack, 0);
        step();
        chk("wr_req2", req, 4'b0100);
        grant = 4'b0100;
        step();
        grant = 0;
        chk("wr_ack", m_ack, 1);
        chk("wr_req_drop", req, 0);
        chk("wr_busy_fall", m_busy, 0);
        chk("wr_no_resp", m_resp, 0);
        step();
        chk("wr_ack_pulse", m_ack, 0);
        chk("wr_no_resp2", m_resp, 0);

        // read from slave 1
        m_req = 1; m_cmd = 0; m_addr = 32'h4000_0000;
        step();
        m_req = 0;
        chk("rd_req", req, 4'b0010);
        grant = 4'b0010;
        sresp = 4'b0010;
        rdata[63:32] = 32'h1111_1111;
        step();
        grant = 0;
        chk("rd_ack", m_ack, 1);
        chk("rd_busy", m_busy, 1);
        chk("rd_req_drop", req, 0);
        chk("rd_resp_grantcyc", m_resp, 0);
        sresp = 4'b1000;
        rdata[127:96] = 32'hCAFE_F00D;
        step();
        chk("rd_other_ign", m_resp, 0);
        chk("rd_busy2", m_busy, 1);
        sresp = 4'b0010;
        rdata[63:32] = 32'hDEAD_BEEF;
        step();
        sresp = 0;
        chk("rd_resp", m_resp, 1);
        chk("rd_err", m_err, 0);
        chk("rd_rdata", m_rdata, 32'hDEAD_BEEF);
        chk("rd_busy_fall", m_busy, 0);
        step();
        chk("rd_resp_pulse", m_resp, 0);

        // three slaves: select 2'b11 is out of range
        m_req3 = 1; m_cmd3 = 0; m_addr3 = 32'hC000_0000;
        step();
        m_req3 = 0;
        chk("de_req", req3, 0);
        chk("de_busy", m_busy3, 1);
        chk("de_resp_early", m_resp3, 0);
        step();
        chk("de_resp", m_resp3, 1);
        chk("de_err", m_err3, 1);
        chk("de_rdata", m_rdata3, 0);
        chk("de_req2", req3, 0);
        chk("de_busy_fall", m_busy3, 0);
        step();
        chk("de_resp_pulse", m_resp3, 0);

        // three slaves: select 2 is valid
        m_req3 = 1; m_cmd3 = 1; m_addr3 = 32'h8000_0000;
        step();
        m_req3 = 0;
        chk("q3_req", req3, 3'b100);
        grant3 = 3'b100;
        step();
        grant3 = 0;
        chk("q3_ack", m_ack3, 1);
        chk("q3_err", m_err3, 0);

        // timeout with no grant
        m_req = 1; m_cmd = 1; m_addr = 32'h0000_0040;
        step();
        m_req = 0;
        for (int i = 0; i < 8; i++) begin
            chk("to_req_held", req, 4'b0001);
            step();
        end
        chk("to_req_drop", req, 0);
        chk("to_busy_err", m_busy, 1);
        chk("to_resp_early", m_resp, 0);
        step();
        chk("to_resp", m_resp, 1);
        chk("to_err", m_err, 1);
        chk("to_busy_fall", m_busy, 0);
        step();
        chk("to_resp_pulse", m_resp, 0);

        // grant on the last cycle before timeout
        m_req = 1; m_cmd = 1; m_addr = 32'h0000_0080;
        step();
        m_req = 0;
        for (int i = 0; i < 7; i++) step();
        chk("tg_req_last", req, 4'b0001);
        grant = 4'b0001;
        step();
        grant = 0;
        chk("tg_ack", m_ack, 1);
        chk("tg_busy", m_busy, 1'b0);
        chk("tg_no_resp", m_resp, 0);
        step();
        chk("tg_no_err", {m_resp, m_err}, 0);

        // reset while waiting for a read response
        m_req = 1; m_cmd = 0; m_addr = 32'hC000_0000;
        step();
        m_req = 0;
        chk("rr_req", req, 4'b1000);
        grant = 4'b1000;
        step();
        grant = 0;
        chk("rr_ack", m_ack, 1);
        step();
        chk("rr_wait_busy", m_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_busy0", m_busy, 0);
        chk("rr_out0", {m_ack, m_resp, m_err, req}, 0);
        chk("rr_data0", {m_rdata, s_addr}, 0);
        #2 rst_n = 1'b1;
        sresp = 4'b1000;
        rdata[127:96] = 32'hBAD0_BAD0;
        step();
        sresp = 0;
        chk("rr_no_stale", m_resp, 0);
        m_req = 1; m_cmd = 0; m_addr = 32'h0000_0004;
        step();
        m_req = 0;
        chk("rr2_req", req, 4'b0001);
        grant = 4'b0001;
        step();
        grant = 0;
        chk("rr2_ack", m_ack, 1);
        chk("rr2_no_resp", m_resp, 0);
        sresp = 4'b0001;
        rdata[31:0] = 32'h0BAD_F00D;
        step();
        sresp = 0;
        chk("rr2_resp", m_resp, 1);
        chk("rr2_err", m_err, 0);
        chk("rr2_rdata", m_rdata, 32'h0BAD_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
